// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed hex driver for an N-digit common-anode display.
// Data is double-buffered (pending -> shadow at frame wrap) so a frame never tears.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzb,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, shad_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_en_q, shad_dp_q, shad_en_q;
    logic                    pend_lzb_q, shad_lzb_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q;
    logic                    wrap, frame_wrap, gap, blank, lz_run;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              nib;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // lz[i] is set when nibbles i..NUM_DIGITS-1 of the shadow value are all zero
    always_comb begin
        lz = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (shad_val_q[4*i +: 4] == 4'd0);
            lz[i] = lz_run;
        end
    end

    always_comb begin
        wrap       = presc_q == PW'(TICK_DIV - 1);
        frame_wrap = wrap && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d    = wrap ? '0 : presc_q + 1'b1;
        idx_d      = frame_wrap ? '0 : wrap ? idx_q + 1'b1 : idx_q;
        gap        = {1'b0, presc_q} < (PW + 1)'(BLANK_CYCLES);
        nib        = shad_val_q[idx_q*4 +: 4];
        blank      = !shad_en_q[idx_q] || (shad_lzb_q && idx_q != '0 && lz[idx_q]);
        seg_d      = (gap || blank) ? 7'h7F : decode(nib);
        dp_d       = (gap || !shad_en_q[idx_q]) ? 1'b1 : !shad_dp_q[idx_q];
        an_d       = gap ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_lzb_q   <= 1'b0;
            shad_val_q   <= '0;
            shad_dp_q    <= '0;
            shad_en_q    <= '0;
            shad_lzb_q   <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_wrap;
            // shadow always takes the pre-edge pending, even if load hits the wrap cycle
            if (frame_wrap) begin
                shad_val_q <= pend_val_q;
                shad_dp_q  <= pend_dp_q;
                shad_en_q  <= pend_en_q;
                shad_lzb_q <= pend_lzb_q;
            end
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
                pend_en_q  <= digit_en;
                pend_lzb_q <= lzb;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule
